// File: rtl/cheby_pkg.sv
// Shared definitions for the Chebyshev lane engine.
//   state_t  : engine FSM states
//   sat_w    : clamp a wide signed value into a w-bit two's-complement range
//   rnd_bias : round-half-up bias added before the fixed-point right shift
package cheby_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

  // FRAC_BITS must be >= 1.
  function automatic logic signed [63:0] rnd_bias(input int frac);
    return 64'sd1 <<< (frac - 1);
  endfunction

endpackage

// File: rtl/cheby_sat_mac.sv
// Two-stage multiply / scale / round / saturate / add-coefficient unit.
//   clk, rst : clock, synchronous active-high reset
//   x, b     : multiplicand and current b_{k+1} of the issued lane
//   coeff    : c_k for the issued step
//   dbl      : 1 when k > 0 (product term is 2*x*b)
//   acc      : sat(sat(round(x*b*(dbl?2:1))) + c_k), two cycles after issue
//   sat      : either saturation fired for that result
module cheby_sat_mac
  import cheby_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] b,
  input  logic signed [WIDTH-1:0] coeff,
  input  logic                    dbl,
  output logic signed [WIDTH-1:0] acc,
  output logic                    sat
);

  logic signed [2*WIDTH-1:0] prod_q;
  logic signed [WIDTH-1:0]   coeff_q;
  logic                      dbl_q;
  logic signed [63:0]        biased, scaled, prod_s, sum, sum_s;

  always_comb begin
    biased = (dbl_q ? (64'(prod_q) <<< 1) : 64'(prod_q)) + rnd_bias(FRAC_BITS);
    scaled = biased >>> FRAC_BITS;
    prod_s = sat_w(scaled, WIDTH);
    sum    = prod_s + 64'(coeff_q);
    sum_s  = sat_w(sum, WIDTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q  <= '0;
      coeff_q <= '0;
      dbl_q   <= 1'b0;
      acc     <= '0;
      sat     <= 1'b0;
    end else begin
      prod_q  <= (2*WIDTH)'(x) * (2*WIDTH)'(b);
      coeff_q <= coeff;
      dbl_q   <= dbl;
      acc     <= WIDTH'(sum_s);
      sat     <= (prod_s != scaled) || (sum_s != sum);
    end
  end

endmodule

// File: rtl/cheby_lane_engine.sv
// Multi-lane Chebyshev series evaluator (Clenshaw recurrence), one shared
// saturating MAC time-multiplexed across lanes.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : job handshake (x_in, coeff_in, deg_in)
//   out_valid/out_ready : result handshake (y_out, ovf)
//   busy                : engine not idle
module cheby_lane_engine
  import cheby_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int FRAC_BITS = 10,
  parameter  int DEGREE    = 3,
  parameter  int LANES     = 4,
  localparam int DW        = (DEGREE < 1) ? 1 : $clog2(DEGREE + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*WIDTH-1:0]        x_in,
  input  logic [(DEGREE+1)*WIDTH-1:0]   coeff_in,
  input  logic [DW-1:0]                 deg_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*WIDTH-1:0]        y_out,
  output logic [LANES-1:0]              ovf,
  output logic                          busy
);

  localparam int             LW        = (LANES < 2) ? 1 : $clog2(LANES);
  localparam int             STAGES    = 2;
  localparam logic [DW-1:0]  DEG_MAX   = DW'(DEGREE);
  localparam logic [LW-1:0]  LANE_LAST = LW'(LANES - 1);

  // A lane's b state must be written back before that lane is issued again.
  generate
    if (LANES < 3) begin : g_lanes_chk
      $error("cheby_lane_engine: LANES must be at least 3");
    end
    if (2*WIDTH + 2 > 64) begin : g_width_chk
      $error("cheby_lane_engine: WIDTH too large for 64-bit intermediates");
    end
  endgenerate

  state_t                        state;
  logic [LW-1:0]                 lane_cnt;
  logic [DW-1:0]                 k_cnt;
  logic                          drain_cnt;
  logic [LANES-1:0][WIDTH-1:0]   x_q, b1, b2, y_q;
  logic [DEGREE:0][WIDTH-1:0]    c_q;
  logic                          accept, issue;

  logic [STAGES:1]               vld_pipe;
  logic [STAGES:1][LW-1:0]       lane_pipe;
  logic [STAGES:1]               k0_pipe;

  logic signed [WIDTH-1:0]       mac_acc;
  logic                          mac_sat;
  logic [LW-1:0]                 wb_lane;
  logic signed [63:0]            diff, diff_s;
  logic [WIDTH-1:0]              wb_val;
  logic                          wb_sat;

  assign accept = (state == IDLE) && in_valid && in_ready;
  assign issue  = (state == RUN);
  assign y_out  = y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      lane_cnt  <= '0;
      k_cnt     <= '0;
      drain_cnt <= 1'b0;
      x_q       <= '0;
      c_q       <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          x_q      <= x_in;
          c_q      <= coeff_in;
          k_cnt    <= (deg_in > DEG_MAX) ? DEG_MAX : deg_in;
          lane_cnt <= '0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          state    <= RUN;
        end
        RUN: begin
          if (lane_cnt == LANE_LAST) begin
            lane_cnt <= '0;
            if (k_cnt == '0) begin
              drain_cnt <= 1'b0;
              state     <= DRAIN;
            end else begin
              k_cnt <= k_cnt - DW'(1);
            end
          end else begin
            lane_cnt <= lane_cnt + LW'(1);
          end
        end
        // Two cycles let the last issued lane reach writeback.
        DRAIN: begin
          if (drain_cnt) begin
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  cheby_sat_mac #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS)) u_mac (
    .clk   (clk),
    .rst   (rst),
    .x     ($signed(x_q[lane_cnt])),
    .b     ($signed(b1[lane_cnt])),
    .coeff ($signed(c_q[k_cnt])),
    .dbl   (k_cnt != '0),
    .acc   (mac_acc),
    .sat   (mac_sat)
  );

  // Writeback: b_k = acc - b_{k+2}, for the lane issued two cycles ago.
  always_comb begin
    wb_lane = lane_pipe[STAGES];
    diff    = 64'(mac_acc) - 64'($signed(b2[wb_lane]));
    diff_s  = sat_w(diff, WIDTH);
    wb_val  = WIDTH'(diff_s);
    wb_sat  = (diff_s != diff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      lane_pipe <= '0;
      k0_pipe   <= '0;
      b1        <= '0;
      b2        <= '0;
      y_q       <= '0;
      ovf       <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[1], issue};
      lane_pipe <= {lane_pipe[1], lane_cnt};
      k0_pipe   <= {k0_pipe[1], (k_cnt == '0)};
      if (accept) begin
        b1  <= '0;
        b2  <= '0;
        ovf <= '0;
      end else if (vld_pipe[STAGES]) begin
        b2[wb_lane] <= b1[wb_lane];
        b1[wb_lane] <= wb_val;
        if (k0_pipe[STAGES]) y_q[wb_lane] <= wb_val;
        if (mac_sat || wb_sat) ovf[wb_lane] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cheby_lane_engine.sv
// Self-checking bench for cheby_lane_engine: directed cases plus random jobs
// against a direct saturating Clenshaw model. A second instance (DEGREE=4,
// LANES=3) covers degree clamping and the minimum lane count.
module tb_cheby_lane_engine;
  localparam int W = 16, F = 10, DG = 3, L = 4, DG4 = 4, L4 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic                  in_valid, in_ready, out_valid, out_ready, busy;
  logic [L*W-1:0]        x_in, y_out;
  logic [(DG+1)*W-1:0]   coeff_in;
  logic [1:0]            deg_in;
  logic [L-1:0]          ovf;

  logic                  in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [L4*W-1:0]       x_in4, y_out4;
  logic [(DG4+1)*W-1:0]  coeff_in4;
  logic [2:0]            deg_in4;
  logic [L4-1:0]         ovf4;

  cheby_lane_engine #(.WIDTH(W), .FRAC_BITS(F), .DEGREE(DG), .LANES(L)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .coeff_in(coeff_in), .deg_in(deg_in),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
    .ovf(ovf), .busy(busy)
  );

  cheby_lane_engine #(.WIDTH(W), .FRAC_BITS(F), .DEGREE(DG4), .LANES(L4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .x_in(x_in4), .coeff_in(coeff_in4), .deg_in(deg_in4),
    .out_valid(out_valid4), .out_ready(out_ready4), .y_out(y_out4),
    .ovf(ovf4), .busy(busy4)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int jx[4];
  int jc[5];
  int jdeg;
  longint ey[4];
  logic   eo[4];

  task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, act, exp);
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Straight Clenshaw loop with every saturation point noted.
  task automatic ref_model(input int nl, input int dmax);
    int d;
    longint b1, b2, p, t, s;
    logic o;
    d = (jdeg > dmax) ? dmax : jdeg;
    for (int l = 0; l < nl; l++) begin
      b1 = 0; b2 = 0; o = 1'b0;
      for (int k = d; k >= 0; k--) begin
        p = longint'(jx[l]) * b1;
        if (k > 0) p = p * 2;
        t = (p + longint'(1 << (F - 1))) >>> F;
        s = sat16(t); if (s != t) o = 1'b1;
        t = s + longint'(jc[k]);
        s = sat16(t); if (s != t) o = 1'b1;
        t = s - b2;
        s = sat16(t); if (s != t) o = 1'b1;
        b2 = b1; b1 = s;
      end
      ey[l] = b1; eo[l] = o;
    end
  endtask

  task automatic start_main(output int t0);
    int i;
    for (int l = 0; l < L; l++) x_in[l*W +: W] = W'(jx[l]);
    for (int k = 0; k <= DG; k++) coeff_in[k*W +: W] = W'(jc[k]);
    deg_in   = 2'(jdeg);
    in_valid = 1'b1;
    i = 0;
    while (!in_ready && i < 100) begin @(negedge clk); i++; end
    t0 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    // Latched values must be used, not whatever sits on the bus now.
    x_in     = {$urandom(), $urandom()};
    coeff_in = {$urandom(), $urandom()};
    deg_in   = 2'($urandom());
  endtask

  task automatic wait_out(input string tag, input int t0);
    int i, d;
    i = 0;
    while (!out_valid && i < 300) begin @(negedge clk); i++; end
    d = (jdeg > DG) ? DG : jdeg;
    chk({tag, "_lat"}, cyc - t0, (d + 1) * L + 3);
    ref_model(L, DG);
    for (int l = 0; l < L; l++) begin
      chk($sformatf("%s_y%0d", tag, l), $signed(y_out[l*W +: W]), ey[l]);
      chk($sformatf("%s_ovf%0d", tag, l), ovf[l], eo[l]);
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, out_valid, 0);
    chk({tag, "_rdy_back"}, in_ready, 1);
  endtask

  task automatic job4(input string tag);
    int t0, i, d;
    for (int l = 0; l < L4; l++) x_in4[l*W +: W] = W'(jx[l]);
    for (int k = 0; k <= DG4; k++) coeff_in4[k*W +: W] = W'(jc[k]);
    deg_in4   = 3'(jdeg);
    in_valid4 = 1'b1;
    i = 0;
    while (!in_ready4 && i < 100) begin @(negedge clk); i++; end
    t0 = cyc;
    @(negedge clk);
    in_valid4 = 1'b0;
    x_in4     = 48'({$urandom(), $urandom()});
    deg_in4   = 3'($urandom());
    i = 0;
    while (!out_valid4 && i < 300) begin @(negedge clk); i++; end
    d = (jdeg > DG4) ? DG4 : jdeg;
    chk({tag, "_lat"}, cyc - t0, (d + 1) * L4 + 3);
    ref_model(L4, DG4);
    for (int l = 0; l < L4; l++) begin
      chk($sformatf("%s_y%0d", tag, l), $signed(y_out4[l*W +: W]), ey[l]);
      chk($sformatf("%s_ovf%0d", tag, l), ovf4[l], eo[l]);
    end
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    chk({tag, "_ov_drop"}, out_valid4, 0);
  endtask

  task automatic rand_job();
    for (int l = 0; l < 4; l++) jx[l] = int'($urandom_range(4096)) - 2048;
    for (int k = 0; k < 5; k++)
      jc[k] = ($urandom_range(3) == 0) ? int'($urandom_range(65535)) - 32768
                                       : int'($urandom_range(6000)) - 3000;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    int t0, bad;
    logic [L*W-1:0] y_sv;
    logic [L-1:0]   o_sv;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; x_in = '0; coeff_in = '0; deg_in = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; x_in4 = '0; coeff_in4 = '0; deg_in4 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y_out, 0);
    chk("rst_ovf", ovf, 0);

    // T3(0.5) = -1
    jx = '{512, 512, 512, 512}; jc = '{0, 0, 0, 1024, 0}; jdeg = 3;
    start_main(t0);
    wait_out("t1", t0);
    chk("t1_y_const", $signed(y_out[0 +: W]), -1024);
    chk("t1_ovf_const", ovf, 0);
    consume("t1");

    // Sum of T0..T3 at 1.0 = 4, with backpressure and a stray in_valid.
    jx = '{1024, 1024, 1024, 1024}; jc = '{1024, 1024, 1024, 1024, 0}; jdeg = 3;
    start_main(t0);
    in_valid = 1'b1; x_in = {$urandom(), $urandom()}; deg_in = 2'd0;
    @(negedge clk);
    chk("t2_poke_rdy", in_ready, 0);
    chk("t2_poke_busy", busy, 1);
    in_valid = 1'b0;
    wait_out("t2", t0);
    chk("t2_y_const", $signed(y_out[3*W +: W]), 4096);
    y_sv = y_out; o_sv = ovf; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || y_out !== y_sv || ovf !== o_sv || in_ready !== 1'b0) bad++;
    end
    chk("t2_hold_bad_cycles", bad, 0);
    consume("t2");

    // Saturating lane next to a clean lane.
    jx = '{1024, 0, 512, -1024}; jc = '{16000, 16000, 16000, 16000, 0}; jdeg = 3;
    start_main(t0);
    wait_out("t3", t0);
    chk("t3_y0_const", $signed(y_out[0 +: W]), 0);
    chk("t3_ovf0_const", ovf[0], 1);
    chk("t3_y1_const", $signed(y_out[W +: W]), 0);
    chk("t3_ovf1_const", ovf[1], 0);
    consume("t3");

    // Degree 0: y = c0 everywhere.
    rand_job(); jc[0] = 300; jdeg = 0;
    start_main(t0);
    wait_out("t4", t0);
    chk("t4_y2_const", $signed(y_out[2*W +: W]), 300);
    consume("t4");

    // Reset in the middle of RUN.
    rand_job(); jdeg = 3;
    start_main(t0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_y", y_out, 0);
    chk("mrst_ovf", ovf, 0);
    chk("mrst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_in_ready", in_ready, 1);
    rand_job(); jdeg = 3;
    start_main(t0);
    wait_out("post_rst", t0);
    consume("post_rst");

    for (int n = 0; n < 12; n++) begin
      rand_job(); jdeg = int'($urandom_range(3));
      start_main(t0);
      wait_out($sformatf("rnd%0d", n), t0);
      consume($sformatf("rnd%0d", n));
    end

    // Second instance: degree clamp and three lanes.
    rand_job(); jdeg = 7;
    job4("clamp7");
    rand_job(); jdeg = 5;
    job4("clamp5");
    rand_job(); jdeg = 2;
    job4("d4_deg2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cheby_lane_engine.md
CHEBY_LANE_ENGINE -- requirements
Module: cheby_lane_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 16: signed fixed-point word width.
REQ-002 SHALL have parameter FRAC_BITS, default 10: fractional bits (1.0 = 1<<FRAC_BITS).
REQ-003 SHALL have parameter DEGREE, default 3: maximum polynomial degree.
REQ-004 SHALL have parameter LANES, default 4: independent evaluations per job; LANES < 3 SHALL be a compile-time error.
REQ-005 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-006 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1: job offered.
REQ-008 SHALL have port in_ready, output, 1: engine accepts job.
REQ-009 SHALL have port x_in, input, LANES*WIDTH: lane i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port coeff_in, input, (DEGREE+1)*WIDTH: c_k at bits [k*WIDTH +: WIDTH], shared by all lanes.
REQ-011 SHALL have port deg_in, input, $clog2(DEGREE+1) (min 1): runtime degree D for this job.
REQ-012 SHALL have port out_valid, output, 1: results available.
REQ-013 SHALL have port out_ready, input, 1: consumer takes results.
REQ-014 SHALL have port y_out, output, LANES*WIDTH: per-lane result, same packing as x_in.
REQ-015 SHALL have port ovf, output, LANES: per-lane sticky saturation flag for the job.
REQ-016 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-017 SHALL compute, per lane, y = sum c_k*T_k(x) for k=0..D via Clenshaw: b_{D+1}=b_{D+2}=0; b_k = c_k + 2x*b_{k+1} - b_{k+2} for k=D..1; y = c_0 + x*b_1 - b_2.
REQ-018 SHALL implement FSM IDLE -> RUN -> DRAIN -> OUT -> IDLE.
REQ-019 SHALL assert in_ready only in IDLE; handshake in_valid&in_ready SHALL latch x_in, coeff_in, and min(deg_in, DEGREE), clear ovf, and enter RUN.
REQ-020 SHALL in RUN issue one lane per cycle, rotating lane 0..LANES-1, with k stepping from D down to 0 after each full rotation; RUN SHALL last (D+1)*LANES cycles.
REQ-021 SHALL use a 3-stage datapath: multiply register, scale/round/add-coefficient register, subtract/writeback into per-lane b state; writeback SHALL target the lane issued 2 cycles earlier.
REQ-022 SHALL stay in DRAIN exactly 2 cycles, then enter OUT.
REQ-023 SHALL, with accept in cycle T0, assert out_valid first in cycle T0+(D+1)*LANES+3 (19 for defaults, D=3).
REQ-024 SHALL hold out_valid, y_out and ovf stable in OUT until out_ready; out_valid&out_ready SHALL return to IDLE next cycle. A new job SHALL NOT be accepted in the same cycle.
REQ-025 SHALL compute the product term as full 2*WIDTH product, shifted left 1 when k>0, plus 1<<(FRAC_BITS-1), arithmetic right-shifted by FRAC_BITS, then saturated to WIDTH.
REQ-026 SHALL saturate the coefficient add and the b_{k+2} subtract to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; any saturation in a lane SHALL set that lane's ovf.
REQ-027 SHALL with D=0 yield y = c_0 for every lane, RUN lasting LANES cycles.
REQ-028 SHALL ignore in_valid, x_in, coeff_in and deg_in outside IDLE.

Reset
REQ-029 SHALL, on rst high at a clock edge (including mid-job), enter IDLE and clear y_out, ovf, out_valid, all b state and pipeline registers to 0; in_ready SHALL be 1 the cycle after rst deasserts.

Structure
REQ-030 SHALL place the FSM state enum, the saturate-to-WIDTH function and the fixed-point rounding constant in shared package cheby_pkg.
REQ-031 SHALL implement the multiply/scale/round/saturate stage as sub-module cheby_sat_mac.

Verification
REQ-032 SHALL test: x=512 all lanes, c=(0,0,0,1024), deg=3 -> y=-1024 all lanes, ovf=0, out_valid at T0+19.
REQ-033 SHALL test: x=1024, c=(1024,1024,1024,1024), deg=3 -> y=4096, ovf=0.
REQ-034 SHALL test: lane0 x=1024, lane1 x=0, c all 16000, deg=3 -> lane0 y=0, ovf[0]=1; lane1 y=0, ovf[1]=0.
REQ-035 SHALL test: deg_in=0, c0=300 -> y=300 all lanes, out_valid at T0+7; deg_in above DEGREE clamps to DEGREE.
REQ-036 SHALL test: out_ready held low 10 cycles -> y_out stable, in_ready=0; in_valid pulsed during RUN is ignored.
REQ-037 SHALL test: rst asserted mid-RUN -> next cycle IDLE, out_valid=0, y_out=0, in_ready=1 after deassertion; the following job is correct.
